// File: rtl/ysyx_25020047_dmem.sv
// Data-memory responder: word-organised SRAM serving lw/lbu/sw/sb with a
// programmable response latency over valid/ready request and response channels.
`timescale 1ns/1ps

module ysyx_25020047_dmem #(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [32:0] SPAN  = 33'(1) << (ADDR_W + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [31:0]       mem [DEPTH];

    logic [31:0]       offset;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              in_range;
    logic              size_err;
    logic              err;
    logic              accept;
    logic [31:0]       rd_word;
    logic [31:0]       rd_data;

    // Request decode; only meaningful on the accept edge.
    always_comb begin
        offset   = req_addr - BASE;
        idx      = offset[ADDR_W+1:2];
        lane     = req_addr[1:0];
        in_range = {1'b0, offset} < SPAN;
        size_err = req_size[0] || (req_size[1] && (lane != 2'b00));
        err      = !in_range || size_err;
        accept   = (state == S_IDLE) && req_valid;
        rd_word  = mem[idx];
        rd_data  = '0;
        if (!err && !req_write) begin
            rd_data = req_size[1] ? rd_word : {24'b0, rd_word[{lane, 3'b000} +: 8]};
        end
    end

    // Next-state logic; WAIT holds for LATENCY cycles in total.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs; response payload captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_RESP);
            if (accept) begin
                rsp_rdata <= rd_data;
                rsp_err   <= err;
            end
        end
    end

    // SRAM array is not reset, so an accepted store survives a later reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !err) begin
            if (req_size[1]) begin
                mem[idx] <= req_wdata;
            end else begin
                mem[idx][{lane, 3'b000} +: 8] <= req_wdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_dmem.sv
// Directed bench for ysyx_25020047_dmem: LATENCY=2 instance for function,
// faults, backpressure and reset; LATENCY=1 instance for throughput.
`timescale 1ns/1ps

module tb_ysyx_25020047_dmem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_1, req_ready_1, req_write_1;
    logic [1:0]  req_size_1;
    logic [31:0] req_addr_1, req_wdata_1;
    logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
    logic [31:0] rsp_rdata_1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_25020047_dmem dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    ysyx_25020047_dmem #(.LATENCY(1)) dut_1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
        .req_size(req_size_1), .req_addr(req_addr_1), .req_wdata(req_wdata_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance with rsp_ready held high.
    task automatic op(input string tag, input logic wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'd2);
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        @(posedge clk);
    endtask

    initial begin
        int lat;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b10;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b1;
        req_valid_1 = 1'b0;
        req_write_1 = 1'b0;
        req_size_1  = 2'b10;
        req_addr_1  = 32'h8000_0100;
        req_wdata_1 = '0;
        rsp_ready_1 = 1'b1;

        repeat (2) @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        op("sw10", 1'b1, 2'b10, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op("lw10", 1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        op("sw20", 1'b1, 2'b10, 32'h8000_0020, 32'h1122_3344, 32'h0, 1'b0);
        op("sb22", 1'b1, 2'b00, 32'h8000_0022, 32'h0000_00AB, 32'h0, 1'b0);
        op("lw20", 1'b0, 2'b10, 32'h8000_0020, 32'h0, 32'h11AB_3344, 1'b0);
        op("lbu23", 1'b0, 2'b00, 32'h8000_0023, 32'h0, 32'h0000_0011, 1'b0);
        op("lbu21", 1'b0, 2'b00, 32'h8000_0021, 32'h0, 32'h0000_0033, 1'b0);

        op("swlast", 1'b1, 2'b10, 32'h8000_0FFC, 32'hA5A5_5A5A, 32'h0, 1'b0);
        op("lwlast", 1'b0, 2'b10, 32'h8000_0FFC, 32'h0, 32'hA5A5_5A5A, 1'b0);

        op("sw00", 1'b1, 2'b10, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 1'b0);
        op("lwmis", 1'b0, 2'b10, 32'h8000_0002, 32'h0, 32'h0, 1'b1);
        op("lwlow", 1'b0, 2'b10, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);
        op("swend", 1'b1, 2'b10, 32'h8000_1000, 32'h1234_5678, 32'h0, 1'b1);
        op("swsz01", 1'b1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op("swmis", 1'b1, 2'b10, 32'h8000_0001, 32'h5555_5555, 32'h0, 1'b1);
        op("lw00", 1'b0, 2'b10, 32'h8000_0000, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Backpressure: hold rsp_ready low for 5 cycles, pulse a store meanwhile.
        op("sw40", 1'b1, 2'b10, 32'h8000_0040, 32'h0BAD_F00D, 32'h0, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h8000_0040;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp.lat", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp.rdata", rsp_rdata, 32'h0BAD_F00D);
            check("bp.err", 32'(rsp_err), 32'd0);
            check("bp.req_ready", 32'(req_ready), 32'd0);
            if (k == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_wdata = 32'h0;
            end else begin
                req_valid = 1'b0;
                req_write = 1'b0;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp.req_ready_after", 32'(req_ready), 32'd1);
        check("bp.rsp_valid_after", 32'(rsp_valid), 32'd0);
        op("lw40", 1'b0, 2'b10, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, 1'b0);

        // Reset while the store is in WAIT.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h8000_0030;
        req_wdata = 32'h0000_00FF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid.req_ready_wait", 32'(req_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid.req_ready", 32'(req_ready), 32'd1);
        check("mid.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op("lw30", 1'b0, 2'b10, 32'h8000_0030, 32'h0, 32'h0000_00FF, 1'b0);

        // LATENCY=1: back-to-back requests accepted every third cycle.
        @(negedge clk);
        req_valid_1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("lat1.req_ready", 32'(req_ready_1), 32'((k % 3) == 0));
            check("lat1.rsp_valid", 32'(rsp_valid_1), 32'((k % 3) == 2));
            @(negedge clk);
        end
        req_valid_1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
